team_06_i2s_tx: RTL and testbench

I2S transmitter for the playback path: takes 8-bit unsigned samples (0..255, the format produced by the capture path) through a valid/ready handshake and serializes them onto `sdata`/`ws` for an external I2S DAC. It uses the same bit-clock scheme as the capture side. `i2sclk` and `past_i2sclk` come from the shared clock divider, and all serial activity is keyed to i2sclk edge events sampled in the `clk` domain. Output frames are 64 bit clocks: a 32-bit left slot and a 32-bit right slot.

---
 rtl/team_06_i2s_pkg.sv | 40 ++++
 rtl/team_06_sample_hold.sv | 48 ++++
 rtl/team_06_i2s_tx.sv | 150 +++++++++++++++
 tb/tb_team_06_i2s_tx.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/team_06_i2s_pkg.sv
// Shared definitions for the I2S capture and playback paths.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package team_06_i2s_pkg;

    localparam int SAMPLE_W = 8;
    localparam int SLOT_W   = 32;

    localparam logic [SAMPLE_W-1:0] MIDSCALE  = 8'd128;
    // Flipping the MSB maps unsigned 0..255 onto two's complement -128..127.
    localparam logic [SAMPLE_W-1:0] SIGN_FLIP = 8'h80;

    typedef enum logic [1:0] {
        IDLE,
        LEFT,
        RIGHT
    } i2s_tx_state_t;

    // Serial bit for slot position k of a slot word {dat, 24'h0}.
    // Position 0 carries the previous slot's LSB padding (I2S one-bit delay),
    // positions 1..8 carry dat MSB first, everything after is zero padding.
    function automatic logic slot_bit(input logic [SAMPLE_W-1:0] dat,
                                      input logic [4:0]          k);
        logic b;
        b = 1'b0;
        case (k)
            5'd1:    b = dat[7];
            5'd2:    b = dat[6];
            5'd3:    b = dat[5];
            5'd4:    b = dat[4];
            5'd5:    b = dat[3];
            5'd6:    b = dat[2];
            5'd7:    b = dat[1];
            5'd8:    b = dat[0];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/team_06_sample_hold.sv
// One-entry sample buffer between the valid/ready input and the frame loader.
// Latency: a transfer is visible on hold_dat/hold_valid the cycle after it.
// Backpressure: upstream is stalled (via hold_valid) while the entry is full.
// Ports: clk/rst (sync, active-high); flush empties the entry; load marks a
// frame load which consumes the entry, or, when empty, takes the same-cycle
// transfer straight through without storing it; xfer is the accepted handshake.
module team_06_sample_hold
    import team_06_i2s_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                load,
    input  logic                xfer,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic [SAMPLE_W-1:0] hold_dat,
    output logic                hold_valid
);

    logic [SAMPLE_W-1:0] hold_dat_q, hold_dat_d;
    logic                hold_valid_q, hold_valid_d;

    always_comb begin
        hold_dat_d   = hold_dat_q;
        hold_valid_d = hold_valid_q;
        if (flush || load) begin
            // A load either drains the entry or bypasses a same-cycle transfer.
            hold_valid_d = 1'b0;
        end else if (xfer) begin
            hold_valid_d = 1'b1;
            hold_dat_d   = sample_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_dat_q   <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            hold_dat_q   <= hold_dat_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    assign hold_dat   = hold_dat_q;
    assign hold_valid = hold_valid_q;

endmodule

// File: rtl/team_06_i2s_tx.sv
// I2S transmitter: 8-bit unsigned samples -> 64-bit-clock I2S frames on sdata/ws.
// Latency: a sample held before a frame-start fall reaches sdata (MSB) one fall later.
// Backpressure: sample_ready = en && !hold_valid; one sample buffered per frame.
// Ports: clk/rst (sync, active-high), en, i2sclk/past_i2sclk (bit clock and its
// one-clk delayed copy), sample_in/sample_valid/sample_ready, sdata, ws, underrun.
// Build option TEAM_06_I2S_TX_DUP_RIGHT_EN: right slot repeats the left sample;
// otherwise the right slot is silent.
module team_06_i2s_tx
    import team_06_i2s_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                i2sclk,
    input  logic                past_i2sclk,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                sdata,
    output logic                ws,
    output logic                underrun
);

    localparam logic [4:0] LAST_BIT = 5'(SLOT_W - 1);

    i2s_tx_state_t       state_q, state_d;
    logic [4:0]          bit_cnt_q, bit_cnt_d;
    logic                sdata_q, sdata_d;
    logic                ws_q, ws_d;
    logic                underrun_q, underrun_d;
    logic [SAMPLE_W-1:0] frame_q, frame_d;   // already sign-converted

    logic                fall;
    logic                xfer;
    logic                load;
    logic [SAMPLE_W-1:0] hold_dat;
    logic                hold_valid;
    logic [SAMPLE_W-1:0] right_dat;
    logic [SAMPLE_W-1:0] src;
    logic [4:0]          nxt_cnt;

    assign fall         = !i2sclk && past_i2sclk;
    assign sample_ready = en && !hold_valid;
    assign xfer         = sample_valid && sample_ready;

`ifdef TEAM_06_I2S_TX_DUP_RIGHT_EN
    assign right_dat = frame_q;
`else
    assign right_dat = '0;
`endif

    team_06_sample_hold u_hold (
        .clk        (clk),
        .rst        (rst),
        .flush      (!en),
        .load       (load),
        .xfer       (xfer),
        .sample_in  (sample_in),
        .hold_dat   (hold_dat),
        .hold_valid (hold_valid)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        sdata_d    = sdata_q;
        ws_d       = ws_q;
        frame_d    = frame_q;
        underrun_d = 1'b0;
        load       = 1'b0;
        src        = MIDSCALE;
        nxt_cnt    = bit_cnt_q + 5'd1;

        if (!en) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            sdata_d   = 1'b0;
            ws_d      = 1'b0;
        end else if (fall) begin
            case (state_q)
                IDLE: begin
                    state_d   = LEFT;
                    bit_cnt_d = '0;
                    ws_d      = 1'b0;
                    sdata_d   = 1'b0;
                    load      = 1'b1;
                end
                LEFT: begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = RIGHT;
                        bit_cnt_d = '0;
                        ws_d      = 1'b1;
                        sdata_d   = 1'b0;
                    end else begin
                        bit_cnt_d = nxt_cnt;
                        sdata_d   = slot_bit(frame_q, nxt_cnt);
                    end
                end
                RIGHT: begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = LEFT;
                        bit_cnt_d = '0;
                        ws_d      = 1'b0;
                        sdata_d   = 1'b0;
                        load      = 1'b1;
                    end else begin
                        bit_cnt_d = nxt_cnt;
                        sdata_d   = slot_bit(right_dat, nxt_cnt);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Frame load priority: held sample, then same-cycle bypass, then silence.
        if (load) begin
            if (hold_valid) begin
                src = hold_dat;
            end else if (xfer) begin
                src = sample_in;
            end else begin
                underrun_d = 1'b1;
            end
            frame_d = src ^ SIGN_FLIP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            sdata_q    <= 1'b0;
            ws_q       <= 1'b0;
            underrun_q <= 1'b0;
            frame_q    <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sdata_q    <= sdata_d;
            ws_q       <= ws_d;
            underrun_q <= underrun_d;
            frame_q    <= frame_d;
        end
    end

    assign sdata    = sdata_q;
    assign ws       = ws_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_team_06_i2s_tx.sv
// Bench for team_06_i2s_tx: frame-position reference model checked every clk,
// a table of sample -> slot-byte vectors, and directed corner-case sequences.
// Latency/backpressure: stimulus waits on bounded cycle budgets only.
module tb_team_06_i2s_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       i2sclk;
    logic       past_i2sclk;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       sample_ready;
    logic       sdata;
    logic       ws;
    logic       underrun;

    always #5 clk = ~clk;

    team_06_i2s_tx dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .i2sclk       (i2sclk),
        .past_i2sclk  (past_i2sclk),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sdata        (sdata),
        .ws           (ws),
        .underrun     (underrun)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Bit clock generator state (half period in clk cycles).
    int half    = 2;
    int div_cnt = 0;

    // Reference model: frames are counted in falls since enable.
    bit       m_active;
    int       m_n;
    bit [7:0] m_q[$];
    bit [7:0] m_cur;
    bit       e_sdata, e_ws, e_under;
    int       last_pos;
    bit       cap[64];

    typedef struct {
        logic [7:0] smp;
        logic [7:0] left;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: cycle budget expired at %0t", name, $time);
    endtask

    // Expected serial bit at position pos (0..63) of a frame carrying raw sample.
    function automatic bit exp_bit(input bit [7:0] raw, input int pos);
        int       k;
        bit [7:0] w;
        k = pos % 32;
        w = raw ^ 8'h80;
        if (pos >= 32) begin
`ifndef TEAM_06_I2S_TX_DUP_RIGHT_EN
            w = 8'h00;
`endif
        end
        if (k < 1 || k > 8) return 1'b0;
        return w[8-k];
    endfunction

    function automatic logic [7:0] cap_byte(input int base);
        logic [7:0] b;
        for (int k = 1; k <= 8; k++) b[8-k] = cap[base+k];
        return b;
    endfunction

    function automatic logic [7:0] exp_right(input logic [7:0] left);
`ifdef TEAM_06_I2S_TX_DUP_RIGHT_EN
        return left;
`else
        return (left & 8'h00);
`endif
    endfunction

    // One clk: check ready, advance the model with the current inputs, clock, compare.
    task automatic step();
        bit fall, xfer;
        #1;
        chk("sample_ready", sample_ready, en && (m_q.size() == 0));
        fall     = !i2sclk && past_i2sclk;
        xfer     = sample_valid && en && (m_q.size() == 0);
        e_under  = 1'b0;
        last_pos = -1;
        if (rst || !en) begin
            m_active = 1'b0;
            m_q.delete();
            m_n     = 0;
            e_sdata = 1'b0;
            e_ws    = 1'b0;
        end else if (fall) begin
            if (!m_active) begin
                m_active = 1'b1;
                m_n      = 0;
            end else begin
                m_n++;
            end
            if (m_n % 64 == 0) begin
                if (m_q.size() > 0) m_cur = m_q.pop_front();
                else if (xfer)      m_cur = sample_in;
                else begin
                    m_cur   = 8'd128;
                    e_under = 1'b1;
                end
            end else if (xfer) begin
                m_q.push_back(sample_in);
            end
            last_pos = m_n % 64;
            e_ws     = (last_pos >= 32);
            e_sdata  = exp_bit(m_cur, last_pos);
        end else if (xfer) begin
            m_q.push_back(sample_in);
        end
        @(posedge clk);
        #1;
        chk("sdata", sdata, e_sdata);
        chk("ws", ws, e_ws);
        chk("underrun", underrun, e_under);
        if (last_pos >= 0) cap[last_pos] = sdata;
        past_i2sclk = i2sclk;
        div_cnt++;
        if (div_cnt >= half) begin
            div_cnt = 0;
            i2sclk  = ~i2sclk;
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        en           = 1'b0;
        sample_valid = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        for (int i = 0; i < 64; i++) cap[i] = 1'b0;
    endtask

    // Run until the fall that sets frame position target in the current frame.
    task automatic run_to_pos(input int target, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 800 && !hit; i++) begin
            step();
            if (last_pos >= 0 && m_n == target) hit = 1'b1;
        end
        if (!hit) timeout(name);
    endtask

    task automatic send_one(input logic [7:0] s);
        sample_valid = 1'b1;
        sample_in    = s;
        step();
        sample_valid = 1'b0;
    endtask

    initial begin
        int vprob;
        rst          = 1'b1;
        en           = 1'b0;
        i2sclk       = 1'b0;
        past_i2sclk  = 1'b0;
        sample_in    = 8'h00;
        sample_valid = 1'b0;
        m_active     = 1'b0;
        m_n          = 0;
        m_cur        = 8'd128;

        tbl[0] = '{smp: 8'hC8, left: 8'h48};
        tbl[1] = '{smp: 8'h00, left: 8'h80};
        tbl[2] = '{smp: 8'hFF, left: 8'h7F};
        tbl[3] = '{smp: 8'h80, left: 8'h00};
        tbl[4] = '{smp: 8'h40, left: 8'hC0};

        // Reset state.
        do_reset();
        chk("reset_sdata", sdata, 1'b0);
        chk("reset_ws", ws, 1'b0);
        chk("reset_underrun", underrun, 1'b0);
        chk("reset_ready", sample_ready, 1'b0);

        // Table: one sample per frame, check left and right slot bytes.
        for (int t = 0; t < 5; t++) begin
            do_reset();
            en = 1'b1;
            send_one(tbl[t].smp);
            run_to_pos(40, "table_run");
            chk("table_left", cap_byte(0), tbl[t].left);
            chk("table_right", cap_byte(32), exp_right(tbl[t].left));
        end

        // Underrun at frame start: one-clk pulse, silent slot, still ready.
        do_reset();
        en = 1'b1;
        run_to_pos(0, "underrun_run");
        chk("underrun_pulse", underrun, 1'b1);
        chk("underrun_ready", sample_ready, 1'b1);
        step();
        chk("underrun_clear", underrun, 1'b0);
        run_to_pos(8, "underrun_slot");
        chk("underrun_left", cap_byte(0), 8'h00);

        // Bypass: sample offered exactly in the frame-start fall cycle.
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 20 && !(!i2sclk && past_i2sclk); i++) step();
        if (!(!i2sclk && past_i2sclk)) timeout("bypass_wait");
        send_one(8'h3C);
        chk("bypass_underrun", underrun, 1'b0);
        run_to_pos(8, "bypass_slot");
        chk("bypass_left", cap_byte(0), 8'hBC);

        // Enable dropped at right-slot bit 12, then a fresh frame.
        do_reset();
        en = 1'b1;
        send_one(8'h40);
        run_to_pos(44, "drop_run");
        chk("drop_ws_before", ws, 1'b1);
        en = 1'b0;
        step();
        chk("drop_sdata", sdata, 1'b0);
        chk("drop_ws", ws, 1'b0);
        chk("drop_ready", sample_ready, 1'b0);
        for (int i = 0; i < 64; i++) cap[i] = 1'b0;
        en = 1'b1;
        send_one(8'h11);
        run_to_pos(8, "reenable_slot");
        chk("reenable_left", cap_byte(0), 8'h91);
        chk("reenable_ws", ws, 1'b0);

        // Randomized traffic against the model.
        do_reset();
        en = 1'b1;
        for (int seg = 0; seg < 6; seg++) begin
            half = $urandom_range(2, 3);
            case ($urandom_range(0, 2))
                0:       vprob = 0;
                1:       vprob = 1;
                default: vprob = 50;
            endcase
            for (int i = 0; i < 500; i++) begin
                en           = ($urandom_range(0, 299) != 0);
                sample_valid = ($urandom_range(0, 99) < vprob);
                sample_in    = 8'($urandom_range(0, 255));
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
